// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-counter checker.
// Holds the state encoding, default widths, and the Gray-to-binary conversion.
package gray_pkg;

    localparam int GRAY_W = 3;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRACK,
        ST_FAULT
    } state_t;

    // Classification of one sample against the previous one
    typedef struct packed {
        logic hold;
        logic step;
        logic wrap;
        logic illegal;
    } step_class_t;

    // Width-agnostic: b = g ^ g>>1 ^ g>>2 ...; callers zero-extend and truncate
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones and never wraps back to zero.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/gray_checker.sv
// Monitors a Gray counter: decodes each sample, flags illegal steps, counts wraps,
// and cross-checks the counter's sticky overflow against the first wrap it sees.
module gray_checker #(
    parameter int WIDTH = gray_pkg::GRAY_W,
    parameter int CNT_W = gray_pkg::CNT_W
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             In_valid,
    input  logic [WIDTH-1:0] Gray_in,
    input  logic             Ovf_in,
    input  logic             Clear,
    output logic [WIDTH-1:0] Bin_out,
    output logic             Bin_valid,
    output logic             Step_err,
    output logic [CNT_W-1:0] Err_count,
    output logic [CNT_W-1:0] Wrap_count,
    output logic             Ovf_mismatch,
    output logic             Locked
);

    import gray_pkg::*;

    localparam logic [WIDTH-1:0] BMAX = '1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] prev_g, prev_b, cur_b;
    logic             prev_ovf, wrap_seen;
    logic             accept, checking, ovf_rise, first_wrap;
    logic             err_inc, wrap_inc;
    step_class_t      cls;

    // Clear wins over a sample in the same cycle
    assign accept   = In_valid && !Clear;
    assign checking = (state != ST_IDLE);
    assign cur_b    = WIDTH'(gray2bin(32'(Gray_in)));

    always_comb begin
        cls         = '0;
        cls.hold    = (Gray_in == prev_g);
        cls.step    = !cls.hold && (cur_b == WIDTH'(prev_b + 1'b1));
        cls.wrap    = cls.step && (prev_b == BMAX);
        cls.illegal = !cls.hold && !cls.step;
    end

    assign ovf_rise   = Ovf_in && !prev_ovf;
    assign first_wrap = cls.wrap && !wrap_seen;
    assign err_inc    = accept && checking && cls.illegal;
    assign wrap_inc   = accept && checking && cls.wrap;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (Clear) begin
            state_nxt = ST_IDLE;
        end else if (In_valid) begin
            case (state)
                ST_IDLE:  state_nxt = ST_TRACK;
                ST_TRACK: if (cls.illegal) state_nxt = ST_FAULT;
                ST_FAULT: state_nxt = ST_FAULT;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Sample history and registered outputs; FAULT keeps tracking so later steps are judged fresh
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            prev_g       <= '0;
            prev_b       <= '0;
            prev_ovf     <= 1'b0;
            wrap_seen    <= 1'b0;
            Bin_out      <= '0;
            Bin_valid    <= 1'b0;
            Step_err     <= 1'b0;
            Ovf_mismatch <= 1'b0;
        end else begin
            Bin_valid <= 1'b0;
            Step_err  <= 1'b0;
            if (Clear) begin
                wrap_seen    <= 1'b0;
                Ovf_mismatch <= 1'b0;
            end else if (In_valid) begin
                prev_g    <= Gray_in;
                prev_b    <= cur_b;
                prev_ovf  <= Ovf_in;
                Bin_out   <= cur_b;
                Bin_valid <= 1'b1;
                if (checking) begin
                    Step_err <= cls.illegal;
                    if (cls.wrap) wrap_seen <= 1'b1;
                    if (ovf_rise != first_wrap) Ovf_mismatch <= 1'b1;
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clr     (Clear),
        .inc     (err_inc),
        .count   (Err_count)
    );

    sat_counter #(.W(CNT_W)) u_wrap_cnt (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clr     (Clear),
        .inc     (wrap_inc),
        .count   (Wrap_count)
    );

    assign Locked = (state == ST_TRACK);

endmodule

// File: tb/tb_gray_checker.sv
// Directed bench for gray_checker: counting, wraps, overflow cross-check,
// illegal steps, saturation, and clear/reset priority.
module tb_gray_checker;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       In_valid = 1'b0;
    logic [2:0] Gray_in = '0;
    logic       Ovf_in = 1'b0;
    logic       Clear = 1'b0;
    logic [2:0] Bin_out;
    logic       Bin_valid;
    logic       Step_err;
    logic [3:0] Err_count;
    logic [3:0] Wrap_count;
    logic       Ovf_mismatch;
    logic       Locked;

    int passed = 0;
    int total  = 0;

    gray_checker dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .In_valid     (In_valid),
        .Gray_in      (Gray_in),
        .Ovf_in       (Ovf_in),
        .Clear        (Clear),
        .Bin_out      (Bin_out),
        .Bin_valid    (Bin_valid),
        .Step_err     (Step_err),
        .Err_count    (Err_count),
        .Wrap_count   (Wrap_count),
        .Ovf_mismatch (Ovf_mismatch),
        .Locked       (Locked)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge
    task automatic smp(input logic v, input logic [2:0] g, input logic ovf, input logic clr);
        In_valid = v;
        Gray_in  = g;
        Ovf_in   = ovf;
        Clear    = clr;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [2:0] gseq [8];
        gseq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

        // Reset state
        #12;
        chk("rst_bin_out", Bin_out, 0);
        chk("rst_bin_valid", Bin_valid, 0);
        chk("rst_step_err", Step_err, 0);
        chk("rst_err_cnt", Err_count, 0);
        chk("rst_wrap_cnt", Wrap_count, 0);
        chk("rst_ovf_mm", Ovf_mismatch, 0);
        chk("rst_locked", Locked, 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Count 0..7
        for (int i = 0; i < 8; i++) begin
            smp(1'b1, gseq[i], 1'b0, 1'b0);
            chk($sformatf("cnt_bin_%0d", i), Bin_out, i);
            chk($sformatf("cnt_valid_%0d", i), Bin_valid, 1);
            chk($sformatf("cnt_err_%0d", i), Step_err, 0);
            chk($sformatf("cnt_locked_%0d", i), Locked, 1);
        end
        chk("cnt_err_count", Err_count, 0);

        // Wrap with overflow rising together
        smp(1'b1, 3'b000, 1'b1, 1'b0);
        chk("wrapovf_bin", Bin_out, 0);
        chk("wrapovf_wrap_cnt", Wrap_count, 1);
        chk("wrapovf_mm", Ovf_mismatch, 0);
        chk("wrapovf_err", Step_err, 0);

        // No valid: no pulse, nothing moves
        smp(1'b0, 3'b101, 1'b1, 1'b0);
        chk("idle_valid", Bin_valid, 0);
        chk("idle_bin", Bin_out, 0);
        chk("idle_wrap_cnt", Wrap_count, 1);

        // Clear
        smp(1'b1, 3'b001, 1'b1, 1'b1);
        chk("clr_valid", Bin_valid, 0);
        chk("clr_wrap_cnt", Wrap_count, 0);
        chk("clr_locked", Locked, 0);
        chk("clr_bin_hold", Bin_out, 0);

        // Wrap without overflow
        for (int i = 0; i < 8; i++) smp(1'b1, gseq[i], 1'b0, 1'b0);
        chk("pre_wrap_bin", Bin_out, 7);
        smp(1'b1, 3'b000, 1'b0, 1'b0);
        chk("wrapnoovf_wrap_cnt", Wrap_count, 1);
        chk("wrapnoovf_mm", Ovf_mismatch, 1);
        smp(1'b1, 3'b001, 1'b0, 1'b0);
        chk("wrapnoovf_mm_sticky", Ovf_mismatch, 1);
        chk("wrapnoovf_locked", Locked, 1);

        // Illegal 001 -> 010, then legal 010 -> 110 while in FAULT
        smp(1'b1, 3'b010, 1'b0, 1'b0);
        chk("ill_step_err", Step_err, 1);
        chk("ill_err_cnt", Err_count, 1);
        chk("ill_locked", Locked, 0);
        chk("ill_bin", Bin_out, 3);
        smp(1'b1, 3'b110, 1'b0, 1'b0);
        chk("fault_legal_err", Step_err, 0);
        chk("fault_legal_cnt", Err_count, 1);
        chk("fault_legal_bin", Bin_out, 4);
        chk("fault_locked", Locked, 0);

        // Clear, then hold 011 for 5 samples
        smp(1'b0, 3'b011, 1'b0, 1'b1);
        chk("clr2_mm", Ovf_mismatch, 0);
        chk("clr2_err_cnt", Err_count, 0);
        for (int i = 0; i < 5; i++) begin
            smp(1'b1, 3'b011, 1'b0, 1'b0);
            chk($sformatf("hold_err_%0d", i), Step_err, 0);
            chk($sformatf("hold_cnt_%0d", i), Err_count, 0);
            chk($sformatf("hold_bin_%0d", i), Bin_out, 2);
            chk($sformatf("hold_locked_%0d", i), Locked, 1);
        end
        chk("hold_wrap_cnt", Wrap_count, 0);

        // 20 illegal steps alternating 011 <-> 000; count saturates at 15
        for (int k = 1; k <= 20; k++) begin
            smp(1'b1, (k % 2 == 1) ? 3'b000 : 3'b011, 1'b0, 1'b0);
            chk($sformatf("sat_pulse_%0d", k), Step_err, 1);
            chk($sformatf("sat_cnt_%0d", k), Err_count, (k > 15) ? 15 : k);
        end
        chk("sat_locked", Locked, 0);

        // Clear with an illegal sample in the same cycle
        smp(1'b1, 3'b000, 1'b0, 1'b1);
        chk("clrill_step_err", Step_err, 0);
        chk("clrill_err_cnt", Err_count, 0);
        chk("clrill_wrap_cnt", Wrap_count, 0);
        chk("clrill_valid", Bin_valid, 0);
        chk("clrill_bin_hold", Bin_out, 2);
        chk("clrill_locked", Locked, 0);

        // Reset between clock edges
        smp(1'b1, 3'b000, 1'b0, 1'b0);
        smp(1'b1, 3'b001, 1'b0, 1'b0);
        chk("pre_rst_bin", Bin_out, 1);
        chk("pre_rst_locked", Locked, 1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_rst_bin", Bin_out, 0);
        chk("async_rst_valid", Bin_valid, 0);
        chk("async_rst_locked", Locked, 0);
        chk("async_rst_err_cnt", Err_count, 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // First sample after reset is an IDLE load, even from a mid-sequence code
        smp(1'b1, 3'b101, 1'b0, 1'b0);
        chk("post_rst_bin", Bin_out, 6);
        chk("post_rst_err", Step_err, 0);
        chk("post_rst_locked", Locked, 1);

        // Overflow rising without a wrap
        smp(1'b1, 3'b100, 1'b1, 1'b0);
        chk("ovf_nowrap_bin", Bin_out, 7);
        chk("ovf_nowrap_err", Step_err, 0);
        chk("ovf_nowrap_mm", Ovf_mismatch, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
